// File: rtl/band_thresh.sv
// Multi-band video binariser: per-band thresholds latched at start of frame,
// hard or ramped band transitions, and a per-frame white-pixel count.
module band_thresh #(
  parameter int PIX_W          = 8,
  parameter int COORD_W        = 16,
  parameter int BANDS          = 4,
  parameter int BAND_ROWS_LOG2 = 7,
  parameter int CNT_W          = 20
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [PIX_W-1:0]         iGray,
  input  logic                     iValid,
  input  logic [COORD_W-1:0]       iX_Cont,
  input  logic [COORD_W-1:0]       iY_Cont,
  input  logic [BANDS*PIX_W-1:0]   iThresh,
  input  logic [1:0]               iMode,
  output logic [PIX_W-1:0]         oPixel,
  output logic                     oValid,
  output logic [PIX_W-1:0]         oThresh,
  output logic [CNT_W-1:0]         oWhiteCnt,
  output logic                     oFrameDone
);

  localparam int K_W    = $clog2(BANDS);
  localparam int PROD_W = PIX_W + BAND_ROWS_LOG2 + 2;

  localparam logic [K_W-1:0]     LAST_K    = K_W'(BANDS - 1);
  localparam logic [COORD_W-1:0] LAST_BAND = COORD_W'(BANDS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [PIX_W-1:0]   PIX_ONES  = '1;

  localparam logic [1:0] MODE_HARD = 2'b00;
  localparam logic [1:0] MODE_RAMP = 2'b01;
  localparam logic [1:0] MODE_BYP  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  // Base plus floor(delta*off / 2^BAND_ROWS_LOG2); the result always lies
  // between the two band thresholds, so the truncation back to PIX_W is exact.
  function automatic logic [PIX_W-1:0] rampThresh(
    input logic [PIX_W-1:0]          base,
    input logic signed [PIX_W:0]     d,
    input logic [BAND_ROWS_LOG2-1:0] off
  );
    logic signed [PROD_W-1:0] dExt;
    logic signed [PROD_W-1:0] offExt;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;
    dExt   = PROD_W'(d);
    offExt = PROD_W'($signed({1'b0, off}));
    prod   = dExt * offExt;
    sum    = PROD_W'($signed({1'b0, base})) + (prod >>> BAND_ROWS_LOG2);
    return sum[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] binarise(
    input logic [PIX_W-1:0] gray,
    input logic [PIX_W-1:0] thr,
    input logic [1:0]       mode
  );
    logic ge;
    ge = (gray >= thr);
    case (mode)
      MODE_BYP: return gray;
      MODE_INV: return ge ? '0 : PIX_ONES;
      default:  return ge ? PIX_ONES : '0;
    endcase
  endfunction

  function automatic logic isWhite(
    input logic [PIX_W-1:0] gray,
    input logic [PIX_W-1:0] thr,
    input logic [1:0]       mode,
    input logic [PIX_W-1:0] pix
  );
    return (mode == MODE_BYP) ? (gray >= thr) : (pix == PIX_ONES);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  logic [BANDS*PIX_W-1:0]   shadowT;
  logic                     sof;
  logic [BANDS*PIX_W-1:0]   tEff;
  logic [COORD_W-1:0]       yBand;
  logic [K_W-1:0]           band;
  logic [K_W-1:0]           bandNext;
  logic [PIX_W-1:0]         tLo;
  logic [PIX_W-1:0]         tHi;
  logic signed [PIX_W:0]    delta;

  logic                      vld_p1, sof_p1;
  logic [1:0]                mode_p1;
  logic [PIX_W-1:0]          gray_p1, tLo_p1;
  logic signed [PIX_W:0]     delta_p1;
  logic [BAND_ROWS_LOG2-1:0] r_p1;

  logic                      vld_p2, sof_p2;
  logic [1:0]                mode_p2;
  logic [PIX_W-1:0]          gray_p2, thresh_p2;

  logic [PIX_W-1:0]          pixOut;
  logic                      white;
  logic [CNT_W-1:0]          whiteCnt;
  logic                      seen;

  // ---- stage 1: SOF detect, shadow select, band decode, threshold select ----
  always_comb begin
    sof      = iValid && (iX_Cont == '0) && (iY_Cont == '0);
    tEff     = sof ? iThresh : shadowT;
    yBand    = iY_Cont >> BAND_ROWS_LOG2;
    band     = (yBand >= LAST_BAND) ? LAST_K : yBand[K_W-1:0];
    bandNext = band + 1'b1;
    tLo      = '0;
    tHi      = '0;
    for (int b = 0; b < BANDS; b++) begin
      if (band == K_W'(b))
        tLo = tEff[b*PIX_W +: PIX_W];
      if ((band != LAST_K) && (bandNext == K_W'(b)))
        tHi = tEff[b*PIX_W +: PIX_W];
    end
    delta = '0;
    if ((iMode == MODE_RAMP) && (band != LAST_K))
      delta = $signed({1'b0, tHi}) - $signed({1'b0, tLo});
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      shadowT <= '0;
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      sof_p2  <= 1'b0;
    end else begin
      if (sof)
        shadowT <= iThresh;
      vld_p1 <= iValid;
      sof_p1 <= sof;
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iValid) begin
      gray_p1  <= iGray;
      mode_p1  <= iMode;
      tLo_p1   <= tLo;
      delta_p1 <= delta;
      r_p1     <= iY_Cont[BAND_ROWS_LOG2-1:0];
    end
  end

  // ---- stage 2: ramp multiply-add ----
  always_ff @(posedge iClk) begin
    if (vld_p1) begin
      gray_p2   <= gray_p1;
      mode_p2   <= mode_p1;
      thresh_p2 <= rampThresh(tLo_p1, delta_p1, r_p1);
    end
  end

  // ---- stage 3: compare, output register, frame statistics ----
  always_comb begin
    pixOut = binarise(gray_p2, thresh_p2, mode_p2);
    white  = isWhite(gray_p2, thresh_p2, mode_p2, pixOut);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oValid     <= 1'b0;
      oPixel     <= '0;
      oThresh    <= '0;
      oWhiteCnt  <= '0;
      oFrameDone <= 1'b0;
      whiteCnt   <= '0;
      seen       <= 1'b0;
    end else begin
      oValid     <= vld_p2;
      oFrameDone <= 1'b0;
      if (vld_p2) begin
        oPixel  <= pixOut;
        oThresh <= thresh_p2;
        if (sof_p2) begin
          // The first frame after reset is partial, so its count is never reported.
          if (seen) begin
            oWhiteCnt  <= whiteCnt;
            oFrameDone <= 1'b1;
          end
          whiteCnt <= white ? CNT_W'(1) : '0;
          seen     <= 1'b1;
        end else if (seen && white) begin
          whiteCnt <= satInc(whiteCnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_band_thresh.sv
// Scoreboard bench for band_thresh: expectations are queued as pixels are
// driven and popped when the DUT presents oValid.
module tb_band_thresh;
  localparam int PIX_W = 8;
  localparam int COORD_W = 16;
  localparam int BANDS = 4;
  localparam int BRL = 7;
  localparam int CNT_W = 10;

  logic                   iClk = 1'b0;
  logic                   iRst_n = 1'b0;
  logic [PIX_W-1:0]       iGray = '0;
  logic                   iValid = 1'b0;
  logic [COORD_W-1:0]     iX_Cont = '0;
  logic [COORD_W-1:0]     iY_Cont = '0;
  logic [BANDS*PIX_W-1:0] iThresh = '0;
  logic [1:0]             iMode = '0;
  logic [PIX_W-1:0]       oPixel;
  logic                   oValid;
  logic [PIX_W-1:0]       oThresh;
  logic [CNT_W-1:0]       oWhiteCnt;
  logic                   oFrameDone;

  band_thresh #(.PIX_W(PIX_W), .COORD_W(COORD_W), .BANDS(BANDS),
                .BAND_ROWS_LOG2(BRL), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iValid(iValid),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iThresh(iThresh), .iMode(iMode),
    .oPixel(oPixel), .oValid(oValid), .oThresh(oThresh),
    .oWhiteCnt(oWhiteCnt), .oFrameDone(oFrameDone));

  always #5 iClk = ~iClk;

  typedef struct {
    int pix;
    int thr;
    int fd;
    int wc;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   pulseVals[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rstSeen = 1'b1;
  int   tbT[BANDS];
  int   tbSeen = 0;
  int   tbCnt = 0;
  int   holdPix = 0;
  int   holdThr = 0;
  logic [BANDS*PIX_W-1:0] curT = '0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelThr(input int y, input logic [1:0] mode);
    int k, r, d;
    k = y >> BRL;
    if (k > BANDS - 1) k = BANDS - 1;
    r = y % (1 << BRL);
    if (mode == 2'b01 && k < BANDS - 1) begin
      d = tbT[k+1] - tbT[k];
      return tbT[k] + ((d * r) >>> BRL);
    end
    return tbT[k];
  endfunction

  function automatic int pv(input int i);
    return (i < pulseVals.size()) ? pulseVals[i] : -1;
  endfunction

  task automatic drivePix(input int gray, input int x, input int y, input logic [1:0] mode);
    exp_t n;
    int thr, ge, white;
    @(posedge iClk); #1;
    iValid  = 1'b1;
    iGray   = PIX_W'(gray);
    iX_Cont = COORD_W'(x);
    iY_Cont = COORD_W'(y);
    iMode   = mode;
    iThresh = curT;
    if (x == 0 && y == 0)
      for (int b = 0; b < BANDS; b++) tbT[b] = int'(curT[b*PIX_W +: PIX_W]);
    thr = modelThr(y, mode);
    ge  = (gray >= thr) ? 1 : 0;
    case (mode)
      2'b10:   n.pix = gray;
      2'b11:   n.pix = ge ? 0 : 255;
      default: n.pix = ge ? 255 : 0;
    endcase
    white = (mode == 2'b10) ? ge : ((n.pix == 255) ? 1 : 0);
    n.thr = thr;
    n.fd  = 0;
    n.wc  = 0;
    n.cyc = cyc + 3;
    if (x == 0 && y == 0) begin
      if (tbSeen != 0) begin
        n.fd = 1;
        n.wc = tbCnt;
      end
      tbCnt  = white;
      tbSeen = 1;
    end else if (tbSeen != 0 && white != 0 && tbCnt < (1 << CNT_W) - 1) begin
      tbCnt++;
    end
    sbq.push_back(n);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk); #1;
      iValid = 1'b0;
      iGray  = PIX_W'($urandom);
    end
  endtask

  task automatic frame(input int w, input int h, input int gray);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        drivePix(gray, x, y, 2'b00);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(posedge iClk); #1;
      iValid = 1'b0;
      n++;
    end
    checkVal("drain", sbq.size(), 0);
    idle(2);
  endtask

  task automatic resetDut();
    @(posedge iClk); #1;
    iRst_n = 1'b0;
    iValid = 1'b0;
    @(posedge iClk); #1;
    sbq.delete();
    tbSeen = 0;
    tbCnt  = 0;
    for (int b = 0; b < BANDS; b++) tbT[b] = 0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
  endtask

  always @(posedge iClk) begin
    cyc     <= cyc + 1;
    rstSeen <= !iRst_n;
  end

  // Output monitor, sampled on the inactive edge.
  always @(negedge iClk) begin
    if (rstSeen) begin
      checkVal("rst_valid", int'(oValid), 0);
      checkVal("rst_pixel", int'(oPixel), 0);
      checkVal("rst_thresh", int'(oThresh), 0);
      checkVal("rst_wcnt", int'(oWhiteCnt), 0);
      checkVal("rst_fdone", int'(oFrameDone), 0);
      holdPix = 0;
      holdThr = 0;
    end else if (oValid) begin
      if (sbq.size() == 0) begin
        checkVal("sb_unexpected", sbq.size(), 1);
      end else begin
        e = sbq.pop_front();
        checkVal("pixel", int'(oPixel), e.pix);
        checkVal("thresh", int'(oThresh), e.thr);
        checkVal("latency", cyc, e.cyc);
        checkVal("fdone", int'(oFrameDone), e.fd);
        if (e.fd != 0) checkVal("wcnt", int'(oWhiteCnt), e.wc);
        holdPix = e.pix;
        holdThr = e.thr;
      end
      if (oFrameDone) pulseVals.push_back(int'(oWhiteCnt));
    end else begin
      checkVal("hold_pixel", int'(oPixel), holdPix);
      checkVal("hold_thresh", int'(oThresh), holdThr);
      checkVal("idle_fdone", int'(oFrameDone), 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=%0d expected=0", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    repeat (3) @(posedge iClk);
    #1 iRst_n = 1'b1;
    checkVal("post_rst_wcnt", int'(oWhiteCnt), 0);
    checkVal("post_rst_valid", int'(oValid), 0);

    // Hard bands including rows past the last band
    curT = {8'd160, 8'd120, 8'd80, 8'd40};
    drivePix(100, 0, 0, 2'b00);
    drivePix(100, 3, 128, 2'b00);
    drivePix(100, 3, 256, 2'b00);
    drivePix(100, 3, 384, 2'b00);
    drivePix(100, 3, 600, 2'b00);
    drain();

    // Ramp with a falling transition, a flat transition and the last band
    curT = {8'd0, 8'd72, 8'd72, 8'd200};
    drivePix(50, 0, 0, 2'b01);
    drivePix(150, 1, 64, 2'b01);
    drivePix(73, 1, 127, 2'b01);
    drivePix(71, 1, 200, 2'b01);
    drivePix(50, 1, 400, 2'b01);
    drain();

    // Mid-frame threshold change must wait for the next SOF pixel
    curT = {8'd160, 8'd120, 8'd80, 8'd40};
    drivePix(100, 0, 0, 2'b00);
    drivePix(100, 2, 300, 2'b00);
    curT = {8'd10, 8'd20, 8'd30, 8'd250};
    drivePix(100, 3, 300, 2'b00);
    drivePix(100, 0, 0, 2'b00);
    drivePix(100, 1, 300, 2'b00);
    drain();

    // Bypass / inverted modes with valid gaps
    curT = {4{8'd100}};
    drivePix(90, 0, 0, 2'b10);
    idle(3);
    drivePix(90, 5, 10, 2'b11);
    idle(2);
    drivePix(90, 6, 10, 2'b10);
    drivePix(150, 7, 10, 2'b11);
    drivePix(150, 8, 10, 2'b10);
    idle(4);
    drain();

    // Frame statistics, including counter saturation
    resetDut();
    p0 = pulseVals.size();
    frame(40, 20, 255);
    frame(64, 20, 255);
    frame(16, 8, 0);
    drivePix(0, 0, 0, 2'b00);
    drain();
    checkVal("stat_npulse", pulseVals.size() - p0, 3);
    checkVal("stat_frame1", pv(p0), 800);
    checkVal("stat_frame2_sat", pv(p0 + 1), 1023);
    checkVal("stat_frame3", pv(p0 + 2), 0);

    // Back-to-back SOF pixels
    p0 = pulseVals.size();
    drivePix(255, 0, 0, 2'b00);
    drivePix(255, 0, 0, 2'b00);
    drivePix(0, 0, 0, 2'b00);
    drain();
    checkVal("b2b_npulse", pulseVals.size() - p0, 3);
    checkVal("b2b_first", pv(p0), 0);
    checkVal("b2b_second", pv(p0 + 1), 1);
    checkVal("b2b_third", pv(p0 + 2), 1);

    // Reset mid-frame with pixels in flight
    drivePix(255, 3, 200, 2'b00);
    drivePix(255, 4, 200, 2'b00);
    drivePix(255, 5, 200, 2'b00);
    resetDut();
    p0 = pulseVals.size();
    frame(8, 2, 255);
    drain();
    checkVal("rst_no_pulse", pulseVals.size() - p0, 0);
    drivePix(255, 0, 0, 2'b00);
    drain();
    checkVal("rst_next_npulse", pulseVals.size() - p0, 1);
    checkVal("rst_next_wcnt", pv(p0), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
